// File: rtl/complex_mult_arbiter_if.sv
// Bus bundle for complex_mult_arbiter. It carries two requester handshakes
// with their complex operand sets, the operand/result path to the shared
// complex multiplier, the per-requester response channels, and busy.
//   slave  : the arbiter's view (takes requests and results; drives ready,
//            multiplier operands, responses, busy)
//   master : the environment's view (requesters plus multiplier)
interface complex_mult_arbiter_if #(
  parameter int W = 8
);
  logic                req0_valid;
  logic                req1_valid;
  logic                req0_ready;
  logic                req1_ready;
  logic signed [W-1:0] req0_a1, req0_b1, req0_a2, req0_b2;
  logic signed [W-1:0] req1_a1, req1_b1, req1_a2, req1_b2;
  logic signed [W-1:0] m_a1, m_b1, m_a2, m_b2;
  logic signed [W-1:0] m_res_re, m_res_im;
  logic                resp0_valid;
  logic                resp1_valid;
  logic signed [W-1:0] resp0_re, resp0_im, resp1_re, resp1_im;
  logic                busy;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_a1, req0_b1, req0_a2, req0_b2,
    input  req1_a1, req1_b1, req1_a2, req1_b2,
    input  m_res_re, m_res_im,
    output req0_ready, req1_ready,
    output m_a1, m_b1, m_a2, m_b2,
    output resp0_valid, resp1_valid,
    output resp0_re, resp0_im, resp1_re, resp1_im,
    output busy
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_a1, req0_b1, req0_a2, req0_b2,
    output req1_a1, req1_b1, req1_a2, req1_b2,
    output m_res_re, m_res_im,
    input  req0_ready, req1_ready,
    input  m_a1, m_b1, m_a2, m_b2,
    input  resp0_valid, resp1_valid,
    input  resp0_re, resp0_im, resp1_re, resp1_im,
    input  busy
  );
endinterface

// File: rtl/complex_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined complex multiplier between two
// requesters. Granted operands are registered onto m_a1..m_b2; a tag
// pipeline follows each operation through the multiplier latency and routes
// the returning result to the owning requester's response registers.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : complex_mult_arbiter_if.slave (requests, multiplier path,
//          responses, busy)
module complex_mult_arbiter #(
  parameter int W        = 8,
  parameter int MULT_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  complex_mult_arbiter_if.slave     bus
);

  localparam int unsigned LAT = MULT_LAT;

  // Arbitration / acceptance
  logic gnt0_c, gnt1_c, rdy0_c, rdy1_c, xfer_c;

  // Last-grant pointer: 0 or 1
  logic last_q, last_d;

  // Registered multiplier operands
  logic signed [W-1:0] m_a1_q, m_b1_q, m_a2_q, m_b2_q;
  logic signed [W-1:0] m_a1_d, m_b1_d, m_a2_d, m_b2_d;

  // Tag pipeline aligned with the multiplier stages
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_id_q,  tag_id_d;

  // Tag that has left the pipeline; its result is on m_res this cycle
  logic ret_vld_q, ret_vld_d;
  logic ret_id_q,  ret_id_d;

  // Response registers
  logic                resp0_valid_q, resp0_valid_d;
  logic                resp1_valid_q, resp1_valid_d;
  logic signed [W-1:0] resp0_re_q, resp0_im_q, resp1_re_q, resp1_im_q;
  logic signed [W-1:0] resp0_re_d, resp0_im_d, resp1_re_d, resp1_im_d;

  // Grant, operand mux, tag shift and response routing
  always_comb begin
    gnt0_c        = 1'b0;
    gnt1_c        = 1'b0;
    rdy0_c        = 1'b0;
    rdy1_c        = 1'b0;
    xfer_c        = 1'b0;
    last_d        = last_q;
    m_a1_d        = '0;
    m_b1_d        = '0;
    m_a2_d        = '0;
    m_b2_d        = '0;
    tag_vld_d     = '0;
    tag_id_d      = '0;
    ret_vld_d     = tag_vld_q[LAT-1];
    ret_id_d      = tag_id_q[LAT-1];
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_re_d    = resp0_re_q;
    resp0_im_d    = resp0_im_q;
    resp1_re_d    = resp1_re_q;
    resp1_im_d    = resp1_im_q;

    // Contest goes to whoever was not granted last (last_q==1 favours 0)
    gnt0_c = bus.req0_valid & (~bus.req1_valid | last_q);
    gnt1_c = bus.req1_valid & (~bus.req0_valid | ~last_q);
    rdy0_c = gnt0_c & ~rst;
    rdy1_c = gnt1_c & ~rst;
    xfer_c = rdy0_c | rdy1_c;

    if (rdy0_c) begin
      last_d = 1'b0;
      m_a1_d = bus.req0_a1;
      m_b1_d = bus.req0_b1;
      m_a2_d = bus.req0_a2;
      m_b2_d = bus.req0_b2;
    end else if (rdy1_c) begin
      last_d = 1'b1;
      m_a1_d = bus.req1_a1;
      m_b1_d = bus.req1_b1;
      m_a2_d = bus.req1_a2;
      m_b2_d = bus.req1_b2;
    end

    tag_vld_d[0] = xfer_c;
    tag_id_d[0]  = rdy1_c;
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    // Result for the retiring tag is present on m_res during this cycle
    if (ret_vld_q) begin
      if (ret_id_q) begin
        resp1_valid_d = 1'b1;
        resp1_re_d    = bus.m_res_re;
        resp1_im_d    = bus.m_res_im;
      end else begin
        resp0_valid_d = 1'b1;
        resp0_re_d    = bus.m_res_re;
        resp0_im_d    = bus.m_res_im;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q        <= 1'b1;
      m_a1_q        <= '0;
      m_b1_q        <= '0;
      m_a2_q        <= '0;
      m_b2_q        <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      ret_vld_q     <= 1'b0;
      ret_id_q      <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_re_q    <= '0;
      resp0_im_q    <= '0;
      resp1_re_q    <= '0;
      resp1_im_q    <= '0;
    end else begin
      last_q        <= last_d;
      m_a1_q        <= m_a1_d;
      m_b1_q        <= m_b1_d;
      m_a2_q        <= m_a2_d;
      m_b2_q        <= m_b2_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      ret_vld_q     <= ret_vld_d;
      ret_id_q      <= ret_id_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_re_q    <= resp0_re_d;
      resp0_im_q    <= resp0_im_d;
      resp1_re_q    <= resp1_re_d;
      resp1_im_q    <= resp1_im_d;
    end
  end

  assign bus.req0_ready  = rdy0_c;
  assign bus.req1_ready  = rdy1_c;
  assign bus.m_a1        = m_a1_q;
  assign bus.m_b1        = m_b1_q;
  assign bus.m_a2        = m_a2_q;
  assign bus.m_b2        = m_b2_q;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp0_re    = resp0_re_q;
  assign bus.resp0_im    = resp0_im_q;
  assign bus.resp1_re    = resp1_re_q;
  assign bus.resp1_im    = resp1_im_q;
  // Anything in the tag pipeline or retiring still owes a response
  assign bus.busy        = (|tag_vld_q) | ret_vld_q;

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Scoreboard bench for complex_mult_arbiter with a behavioural pipelined
// complex multiplier of latency L.
module tb_complex_mult_arbiter;

  localparam int W = 8;
  localparam int L = 2;

  typedef struct packed {
    logic signed [W-1:0] a1;
    logic signed [W-1:0] b1;
    logic signed [W-1:0] a2;
    logic signed [W-1:0] b2;
  } ops_t;

  typedef struct {
    int id;
    int re;
    int im;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   last_m = 1'b1;
  int   last0_re = 0, last0_im = 0, last1_re = 0, last1_im = 0;
  exp_t q[$];

  complex_mult_arbiter_if #(.W(W)) bus ();

  complex_mult_arbiter #(.W(W), .MULT_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: L register stages from m_* to m_res
  logic signed [W-1:0] pre_q [L];
  logic signed [W-1:0] pim_q [L];
  always @(posedge clk) begin
    pre_q[0] <= W'(int'(bus.m_a1) * int'(bus.m_a2) - int'(bus.m_b1) * int'(bus.m_b2));
    pim_q[0] <= W'(int'(bus.m_a1) * int'(bus.m_b2) + int'(bus.m_b1) * int'(bus.m_a2));
    for (int i = 1; i < L; i++) begin
      pre_q[i] <= pre_q[i-1];
      pim_q[i] <= pim_q[i-1];
    end
  end
  assign bus.m_res_re = pre_q[L-1];
  assign bus.m_res_im = pim_q[L-1];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int trunc(input int x);
    logic signed [W-1:0] t;
    t = W'(x);
    return int'(t);
  endfunction

  function automatic int cre(input ops_t o);
    return trunc(int'(o.a1) * int'(o.a2) - int'(o.b1) * int'(o.b2));
  endfunction

  function automatic int cim(input ops_t o);
    return trunc(int'(o.a1) * int'(o.b2) + int'(o.b1) * int'(o.a2));
  endfunction

  function automatic ops_t rnd_ops();
    ops_t o;
    o.a1 = W'($urandom);
    o.b1 = W'($urandom);
    o.a2 = W'($urandom);
    o.b2 = W'($urandom);
    return o;
  endfunction

  // One clock of stimulus: drive, check ready, score transfers, check m_*
  task automatic cyc_drive(input logic r, input logic v0, input ops_t p0,
                           input logic v1, input ops_t p1);
    bit   g0, g1;
    ops_t em;
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_a1 = p0.a1; bus.req0_b1 = p0.b1; bus.req0_a2 = p0.a2; bus.req0_b2 = p0.b2;
    bus.req1_a1 = p1.a1; bus.req1_b1 = p1.b1; bus.req1_a2 = p1.a2; bus.req1_b2 = p1.b2;
    #1;
    g0 = !r && v0 && (!v1 || last_m);
    g1 = !r && v1 && (!v0 || !last_m);
    chk("ready0", bus.req0_ready, g0);
    chk("ready1", bus.req1_ready, g1);
    em = '0;
    if (r) begin
      q.delete();
      last_m = 1'b1;
      last0_re = 0; last0_im = 0; last1_re = 0; last1_im = 0;
    end else if (g0 || g1) begin
      em = g0 ? p0 : p1;
      e.id = g0 ? 0 : 1;
      e.re = cre(em);
      e.im = cim(em);
      e.due = cyc + L + 2;
      q.push_back(e);
      last_m = g1;
    end
    @(posedge clk);
    #2;
    chk("m_a1", bus.m_a1, em.a1);
    chk("m_b1", bus.m_b1, em.b1);
    chk("m_a2", bus.m_a2, em.a2);
    chk("m_b2", bus.m_b2, em.b2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Response monitor: pops the scoreboard on each pulse, checks hold and busy
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (bus.resp0_valid && bus.resp1_valid) chk("dual_pulse", 1, 0);
      if (bus.resp0_valid) begin
        if (q.size() == 0) chk("spurious0", 1, 0);
        else begin
          e = q.pop_front();
          chk("resp_id", 0, e.id);
          chk("resp0_re", bus.resp0_re, e.re);
          chk("resp0_im", bus.resp0_im, e.im);
          chk("resp0_lat", cyc, e.due);
          last0_re = e.re; last0_im = e.im;
        end
      end else begin
        chk("hold0_re", bus.resp0_re, last0_re);
        chk("hold0_im", bus.resp0_im, last0_im);
      end
      if (bus.resp1_valid) begin
        if (q.size() == 0) chk("spurious1", 1, 0);
        else begin
          e = q.pop_front();
          chk("resp_id", 1, e.id);
          chk("resp1_re", bus.resp1_re, e.re);
          chk("resp1_im", bus.resp1_im, e.im);
          chk("resp1_lat", cyc, e.due);
          last1_re = e.re; last1_im = e.im;
        end
      end else begin
        chk("hold1_re", bus.resp1_re, last1_re);
        chk("hold1_im", bus.resp1_im, last1_im);
      end
      if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("missing_resp", cyc, e.due);
      end
      chk("busy", bus.busy, q.size() != 0);
    end
  end

  initial begin
    ops_t o;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    {bus.req0_a1, bus.req0_b1, bus.req0_a2, bus.req0_b2} = '0;
    {bus.req1_a1, bus.req1_b1, bus.req1_a2, bus.req1_b2} = '0;

    // Reset with both requesters valid: no ready, outputs cleared
    cyc_drive(1'b1, 1'b1, rnd_ops(), 1'b1, rnd_ops());
    cyc_drive(1'b1, 1'b1, rnd_ops(), 1'b1, rnd_ops());
    chk("rst_resp0_valid", bus.resp0_valid, 0);
    chk("rst_resp1_valid", bus.resp1_valid, 0);
    chk("rst_resp0_re", bus.resp0_re, 0);
    chk("rst_resp0_im", bus.resp0_im, 0);
    chk("rst_resp1_re", bus.resp1_re, 0);
    chk("rst_resp1_im", bus.resp1_im, 0);
    chk("rst_busy", bus.busy, 0);
    mon_en = 1'b1;

    // Contest: both valid six cycles, grants alternate starting with 0
    for (int i = 0; i < 6; i++) begin
      cyc_drive(1'b0, 1'b1, rnd_ops(), 1'b1, rnd_ops());
      chk("contest_grant", bus.m_a1 === bus.req1_a1 && bus.m_b1 === bus.req1_b1 &&
          bus.m_a2 === bus.req1_a2 && bus.m_b2 === bus.req1_b2 && bus.req0_a1 !== bus.req1_a1,
          (i % 2) == 1 && bus.req0_a1 !== bus.req1_a1);
    end
    idle(6);

    // Single op with known result
    o.a1 = -8'sd3; o.b1 = 8'sd9; o.a2 = 8'sd10; o.b2 = 8'sd9;
    cyc_drive(1'b0, 1'b1, o, 1'b0, '0);
    idle(3);
    chk("single_vld", bus.resp0_valid, 1);
    chk("single_re", bus.resp0_re, -111);
    chk("single_im", bus.resp0_im, 63);
    chk("single_vld1", bus.resp1_valid, 0);
    idle(3);

    // Streaming on requester 1
    for (int i = 0; i < 5; i++) begin
      cyc_drive(1'b0, 1'b0, '0, 1'b1, rnd_ops());
      chk("stream_busy", bus.busy, 1);
    end
    idle(5);

    // Idle zeroing
    idle(5);
    chk("idle_busy", bus.busy, 0);

    // Reset mid-flight discards the pending response
    cyc_drive(1'b0, 1'b1, rnd_ops(), 1'b0, '0);
    cyc_drive(1'b1, 1'b0, '0, 1'b0, '0);
    chk("midrst_busy", bus.busy, 0);
    idle(5);
    cyc_drive(1'b0, 1'b1, rnd_ops(), 1'b1, rnd_ops());
    cyc_drive(1'b0, 1'b1, rnd_ops(), 1'b1, rnd_ops());
    idle(5);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      cyc_drive(1'b0, 1'($urandom_range(0, 1)), rnd_ops(),
                1'($urandom_range(0, 1)), rnd_ops());
    end
    idle(8);
    chk("queue_empty", q.size(), 0);
    chk("final_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
